// File: rtl/spi_rx_slave.sv
// SPI mode-0 peripheral receiver: synchronizes SCLK/CS_N/MOSI into clk and
// assembles MSB-first words; optional MISO shifter (SPI_RX_SLAVE_MISO_EN).
// Ports: clk, n_rst (async low); sclk_in, cs_n_in, mosi_in (async pins);
//   tx_data (response word), miso_out/miso_oe (MISO pad);
//   rx_data/rx_valid (received word strobe), frame_err (mid-word CS abort).
module spi_rx_slave #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             sclk_in,
  input  logic             cs_n_in,
  input  logic             mosi_in,
  input  logic [WIDTH-1:0] tx_data,
  output logic             miso_out,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   sclk_q;
  logic                   cs_q;
  logic                   armed;

  state_t                 state;
  logic [CW-1:0]          bit_cnt;
  logic [WIDTH-2:0]       shift;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic cs_fall, cs_rise;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      fill      <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // The cs chain resets to idle-high, so a pin already low at reset
  // release would look like a falling edge.  A start is only accepted
  // once a genuine high level has made it through the chain.
  assign cs_fall   = armed & cs_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_q;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      armed     <= 1'b0;
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      armed     <= armed | (fill[SYNC_STAGES-1] & cs_s);
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ACTIVE;
            bit_cnt <= '0;
            shift   <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state     <= IDLE;
            frame_err <= (bit_cnt != '0);
            bit_cnt   <= '0;
          end else if (sclk_rise) begin
            shift <= (WIDTH-1)'({shift, mosi_s});
            if (bit_cnt == LAST) begin
              rx_data  <= {shift, mosi_s};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_RX_SLAVE_MISO_EN
  logic [WIDTH-1:0] tx_shift;
  logic             tx_hold;

  // After a word-boundary reload the new MSB is already on the pin; the
  // falling edge that follows must not shift it away before the master
  // samples it on the next rising edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_shift <= '0;
      tx_hold  <= 1'b0;
      miso_oe  <= 1'b0;
    end else if (state == IDLE) begin
      if (cs_fall) begin
        tx_shift <= tx_data;
        tx_hold  <= 1'b0;
        miso_oe  <= 1'b1;
      end
    end else if (cs_rise) begin
      tx_shift <= '0;
      tx_hold  <= 1'b0;
      miso_oe  <= 1'b0;
    end else if (sclk_rise) begin
      if (bit_cnt == LAST) begin
        tx_shift <= tx_data;
        tx_hold  <= 1'b1;
      end
    end else if (sclk_fall) begin
      if (tx_hold) begin
        tx_hold <= 1'b0;
      end else begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign miso_out = tx_shift[WIDTH-1];
`else
  logic unused_tx;

  assign unused_tx = ^tx_data;
  assign miso_out  = 1'b0;
  assign miso_oe   = 1'b0;
`endif

endmodule
